// File: rtl/rotate_ctrl_if.sv
// Request/command bundle between a requester, the rotate sequencer and the
// downstream rotating shifter.
interface rotate_ctrl_if #(
    parameter int N  = 8,
    parameter int CW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  in_data;
    logic [CW-1:0] in_count;
    logic          pause;
    logic          abort;
    logic [N-1:0]  sh_data;
    logic          load;
    logic          shift_ena;
    logic          busy;
    logic          done;

    modport master (
        output in_valid, in_data, in_count, pause, abort,
        input  in_ready, sh_data, load, shift_ena, busy, done
    );

    modport slave (
        input  in_valid, in_data, in_count, pause, abort,
        output in_ready, sh_data, load, shift_ena, busy, done
    );
endinterface

// File: rtl/rotate_ctrl.sv
// Sequencer for the n-bit rotating shifter: one load cycle followed by
// exactly COUNT right-rotate cycles, with pause/abort and a done pulse.
module rotate_ctrl #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic         clock,
    input  logic         reset,
    rotate_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  data_q, data_d;
    logic          load_s;
    logic          shift_s;

    // Next-state, counter and shifter-command decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        load_s  = 1'b0;
        shift_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    cnt_d   = bus.in_count;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else begin
                    load_s  = 1'b1;
                    shift_s = 1'b1;
                    if (cnt_q == {CW{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (bus.pause) begin
                    state_d = ST_SHIFT;
                end else begin
                    shift_s = 1'b1;
                    cnt_d   = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, rotate counter and captured word.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CW{1'b0}};
            data_q  <= {N{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Reset masks every strobe so a mid-operation reset never shifts or completes.
    assign bus.in_ready  = (state_q == ST_IDLE) & ~reset;
    assign bus.busy      = (state_q != ST_IDLE) & ~reset;
    assign bus.done      = (state_q == ST_DONE) & ~reset;
    assign bus.load      = load_s & ~reset;
    assign bus.shift_ena = shift_s & ~reset;
    assign bus.sh_data   = data_q;

endmodule

// File: tb/tb_rotate_ctrl.sv
// Bench for rotate_ctrl: directed vector table, hand sequences for reset,
// and randomized transactions against a transaction-level reference.
module tb_rotate_ctrl;
    localparam int N  = 8;
    localparam int CW = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    rotate_ctrl_if #(.N(N), .CW(CW)) bus ();
    rotate_ctrl #(.N(N), .CW(CW)) dut (.clock(clock), .reset(reset), .bus(bus));

    // Attached rotating shifter: q[i] <= q[i+1], q[N-1] <= q[0].
    logic [N-1:0] outp;
    always_ff @(posedge clock) begin
        if (bus.shift_ena) outp <= bus.load ? bus.sh_data : {outp[0], outp[N-1:1]};
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int k);
        int s;
        s = k % N;
        if (s == 0) return x;
        return (x >> s) | (x << (N - s));
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [7:0] data;
        logic [3:0] count;
        int         p_at;
        int         p_len;
        int         ab_at;
        int         exp_done;
        logic       chk_outp;
        logic [7:0] exp_outp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_c;
        int rem;
        int k;
        logic [7:0] d;
        logic e_load, e_sh, e_done, fin;

        vecs[0] = '{8'b1001_0110, 4'd3,  0, 0, 0, 5,  1'b1, 8'b1101_0010};
        vecs[1] = '{8'h3C,        4'd0,  0, 0, 0, 2,  1'b1, 8'h3C};
        vecs[2] = '{8'hA1,        4'd2,  3, 2, 0, 6,  1'b1, 8'h68};
        vecs[3] = '{8'h81,        4'd5,  0, 0, 3, 0,  1'b1, 8'hC0};
        vecs[4] = '{8'h96,        4'd9,  0, 0, 0, 11, 1'b1, 8'h4B};
        vecs[5] = '{8'h01,        4'd15, 0, 0, 0, 17, 1'b1, 8'h02};
        vecs[6] = '{8'h5A,        4'd8,  0, 0, 0, 10, 1'b1, 8'h5A};
        vecs[7] = '{8'hFF,        4'd4,  0, 0, 1, 0,  1'b1, 8'h5A};

        // Reset held two cycles with a pending request.
        reset = 1'b1;
        bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.in_count = 4'd3;
        bus.pause = 1'b0; bus.abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("rst_ready", bus.in_ready, 0);
            chk("rst_load", bus.load, 0);
            chk("rst_shift", bus.shift_ena, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_busy", bus.busy, 0);
            step();
        end
        reset = 1'b0; bus.in_valid = 1'b0;
        #1;
        chk("post_rst_ready", bus.in_ready, 1);
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_shdata", bus.sh_data, 0);
        step();

        // Directed vector table.
        for (int v = 0; v < 8; v++) begin
            bus.in_valid = 1'b1; bus.in_data = vecs[v].data; bus.in_count = vecs[v].count;
            bus.pause = 1'b0; bus.abort = 1'b0;
            #1;
            chk("vec_ready", bus.in_ready, 1);
            step();
            bus.in_valid = 1'b0; bus.in_data = ~vecs[v].data;
            done_c = 0;
            for (int c = 1; c <= 40 && done_c == 0; c++) begin
                bus.pause = (c >= vecs[v].p_at) && (c < vecs[v].p_at + vecs[v].p_len);
                bus.abort = (c == vecs[v].ab_at);
                #1;
                if (c == 1) chk("vec_load_c1", bus.load, (vecs[v].ab_at != 1));
                if (bus.abort) chk("vec_abort_shift", bus.shift_ena, 0);
                if (bus.done) done_c = c;
                step();
                if (c == vecs[v].ab_at) break;
            end
            bus.pause = 1'b0; bus.abort = 1'b0;
            chk("vec_done_cycle", done_c, vecs[v].exp_done);
            if (vecs[v].chk_outp) chk("vec_outp", outp, vecs[v].exp_outp);
            #1;
            chk("vec_ready_after", bus.in_ready, 1);
            chk("vec_shdata", bus.sh_data, vecs[v].data);
        end
        step();

        // Reset in the middle of a shift sequence.
        bus.in_valid = 1'b1; bus.in_data = 8'h33; bus.in_count = 4'd6;
        step();
        bus.in_valid = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        #1;
        chk("midrst_shift", bus.shift_ena, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_ready", bus.in_ready, 0);
        step();
        reset = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_ready_after", bus.in_ready, 1);
        chk("midrst_shdata", bus.sh_data, 0);
        step();

        // Random transactions, in_valid held high with junk while busy.
        bus.in_valid = 1'b1;
        for (int t = 0; t < 30; t++) begin
            d = 8'($urandom);
            k = $urandom_range(0, 15);
            bus.in_data = d; bus.in_count = 4'(k);
            bus.pause = ($urandom_range(0, 3) == 0);
            #1;
            chk("rnd_ready", bus.in_ready, 1);
            step();
            bus.in_data = 8'($urandom); bus.in_count = 4'($urandom);
            rem = k;
            fin = 1'b0;
            for (int c = 1; c <= 100 && !fin; c++) begin
                bus.pause = ($urandom_range(0, 3) == 0);
                #1;
                if (c == 1) begin
                    e_load = 1'b1; e_sh = 1'b1; e_done = 1'b0;
                end else if (rem > 0) begin
                    e_load = 1'b0; e_sh = !bus.pause; e_done = 1'b0;
                    if (!bus.pause) rem--;
                end else begin
                    e_load = 1'b0; e_sh = 1'b0; e_done = 1'b1;
                end
                chk("rnd_load", bus.load, e_load);
                chk("rnd_shift", bus.shift_ena, e_sh);
                chk("rnd_done", bus.done, e_done);
                chk("rnd_busy", bus.busy, 1);
                chk("rnd_ready_busy", bus.in_ready, 0);
                chk("rnd_shdata", bus.sh_data, d);
                fin = e_done;
                step();
            end
            if (!fin) chk("rnd_timeout", 0, 1);
            chk("rnd_outp", outp, rotr(d, k));
        end
        bus.in_valid = 1'b0; bus.pause = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
